max_pooling_layer: RTL and testbench
====================================

Name: max_pooling_layer

Overview:
- 2x2, stride-2 max-pooling stage directly downstream of the convolutional layer.
- Consumes that layer's raster-order multi-channel pixel stream, qualified by its valid output and the shared clk_en.
- Emits one pooled pixel per channel for every 2x2 window, in raster order.
- Keeps one row of partial maxima per channel in an internal line buffer, so the layer runs at full stream rate without stalls.

Parameters:
- D_WIDTH, 16: bits per channel sample; signed two's complement, same width in and out.
- CHANNELS, 1: number of parallel channels; equals the upstream Q_CHANNELS.
- IN_SIZE, 28: width and height of the input image in accepted pixels.
  - Odd values allowed; the trailing column/row is dropped.

Ports:
- clk, input, 1: single clock; all state changes on the rising edge.
- rst_n, input, 1: reset, asynchronous and active-low.
- clk_en, input, 1: global clock enable. When low, all registers hold, including out_valid and frame_done.
- in_valid, input, 1: input pixel qualifier; connect to the upstream valid.
- input_data, input, D_WIDTH*CHANNELS: channel i occupies bits [D_WIDTH*(i+1)-1 : D_WIDTH*i].
- output_data, output, D_WIDTH*CHANNELS: pooled pixel, same packing as input_data; registered.
- out_valid, output, 1: output_data holds a new pooled pixel; registered.
- frame_done, output, 1: the last pixel of an input frame was accepted on the previous enabled edge; registered.

Behaviour:
- Accept: a pixel is accepted on a rising edge where clk_en=1 and in_valid=1. Nothing else advances state.
- Counters:
  - col counts 0..IN_SIZE-1. On accept, col=IN_SIZE-1 wraps to 0 and increments row.
  - row counts 0..IN_SIZE-1. row=IN_SIZE-1 wraps to 0.
  - Both counters are $clog2(IN_SIZE) bits wide, minimum 1.
- Per-channel datapath, on accept:
  - col even: hold_reg <= pixel.
  - col odd: m = max(hold_reg, pixel), compared signed.
  - col odd, row even: line_buf[col>>1] <= m.
  - col odd, row odd: output_data <= max(line_buf[col>>1], m), compared signed; out_valid <= 1.
- Line buffer: depth IN_SIZE/2 (floor) entries of D_WIDTH*CHANNELS bits. It is written only on even rows and read only on odd rows at the same index, so no read/write collision exists.
- out_valid:
  - On every enabled edge (clk_en=1) that does not produce a pooled pixel, out_valid <= 0. This includes in_valid=0.
  - out_valid is therefore a one-enabled-cycle pulse.
  - Latency: output is visible immediately after the edge accepting pixel (2r+1, 2c+1).
- output_data: holds its last value when no new result is produced.
- frame_done: <= 1 on the enabled edge accepting pixel (IN_SIZE-1, IN_SIZE-1); <= 0 on every other enabled edge.
- Odd IN_SIZE:
  - The last column (even index) is written to hold_reg and never used.
  - The last row (even index) is written to the line buffer and never read.
  - The next frame's row 0 overwrites those entries. Output count is floor(IN_SIZE/2)^2 per frame.
- Ties: equal values return that value; the comparison uses >=.
- Most negative value (-2^(D_WIDTH-1)) must compare correctly; no overflow is possible since only comparisons are performed.
- Reset (rst_n low, any time, including mid-frame):
  - col, row, out_valid, frame_done <= 0; output_data <= 0; hold_reg <= 0.
  - Line buffer needs no reset, since row 0 rewrites it before any read.
  - After release, the next accepted pixel is treated as (0,0).
- Gaps: in_valid may drop for any number of cycles anywhere in the frame, including mid-pair and mid-row. Results must be identical to a gapless stream.
- Back-to-back frames: pixel (0,0) of frame N+1 may be accepted on the edge right after the last pixel of frame N.
- Implementation: no combinational path from inputs to outputs.

Test Plan:
- Basic pooling, IN_SIZE=4, CHANNELS=1, D_WIDTH=8, gapless frame 1..16 in raster order -> out_valid pulses exactly 4 times; outputs 6, 8, 14, 16; frame_done pulses once, after pixel 16.
- Signed compare, 2x2 frame {-128, -1, -5, -2} -> output -1.
- Signed compare, 2x2 frame {-128, -128, -128, -128} -> output -128 (0x80).
- Multi-channel, CHANNELS=2, IN_SIZE=2, ch0 {3,9,1,2}, ch1 {-7,-3,-9,-4} -> output_data = {ch1=-3, ch0=9} in one pulse.
- Gaps and clk_en:
  - Repeat the basic test with in_valid low for 3 cycles after every pixel, and clk_en low on random cycles -> identical outputs and order.
  - out_valid is held, not cleared, while clk_en=0.
- Odd size, IN_SIZE=5, pixels 1..25 -> exactly 4 outputs: 7, 9, 17, 19; frame_done after pixel 25.
- Reset mid-frame and back-to-back:
  - Assert rst_n low after 6 pixels of a 4x4 frame -> out_valid=0 and output_data=0 immediately, asynchronously.
  - A fresh frame 1..16 then yields 6, 8, 14, 16.
  - Two frames sent back-to-back -> 8 outputs, with no corruption across the boundary.

Source files
------------

// File: rtl/max_pooling_layer.sv
// 2x2 stride-2 signed max-pooling over a raster-order multi-channel pixel stream.
// One row of horizontal pair maxima is parked per channel until the odd row arrives.
module max_pooling_layer #(
  parameter int D_WIDTH  = 16,
  parameter int CHANNELS = 1,
  parameter int IN_SIZE  = 28
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clk_en,
  input  logic                          in_valid,
  input  logic [D_WIDTH*CHANNELS-1:0]   input_data,
  output logic [D_WIDTH*CHANNELS-1:0]   output_data,
  output logic                          out_valid,
  output logic                          frame_done
);

  localparam int DW       = D_WIDTH * CHANNELS;
  localparam int CW       = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;
  localparam int LB_DEPTH = (IN_SIZE / 2 > 0) ? IN_SIZE / 2 : 1;
  localparam int AW       = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(IN_SIZE - 1);

  // Lane-wise signed max; ties return a (identical value either way).
  function automatic logic [DW-1:0] chan_max(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if ($signed(a[i*D_WIDTH +: D_WIDTH]) >= $signed(b[i*D_WIDTH +: D_WIDTH]))
        r[i*D_WIDTH +: D_WIDTH] = a[i*D_WIDTH +: D_WIDTH];
      else
        r[i*D_WIDTH +: D_WIDTH] = b[i*D_WIDTH +: D_WIDTH];
    end
    return r;
  endfunction

  logic [CW-1:0] col_q, col_d;
  logic [CW-1:0] row_q, row_d;
  logic [DW-1:0] hold_q, hold_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic          frame_done_q, frame_done_d;

  logic [DW-1:0] line_buf [LB_DEPTH];
  logic [AW-1:0] lb_idx;
  logic [DW-1:0] lb_rdata;
  logic [DW-1:0] pair_max;
  logic          lb_we;
  logic          accept;

  assign accept   = clk_en & in_valid;
  assign lb_idx   = AW'(col_q >> 1);
  assign lb_rdata = line_buf[lb_idx];
  assign pair_max = chan_max(hold_q, input_data);

  // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    hold_d       = hold_q;
    out_data_d   = out_data_q;
    out_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    lb_we        = 1'b0;
    if (accept) begin
      if (col_q == LAST) begin
        col_d = '0;
        row_d = (row_q == LAST) ? '0 : row_q + CW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
      frame_done_d = (col_q == LAST) && (row_q == LAST);
      if (!col_q[0]) begin
        hold_d = input_data;
      end else if (!row_q[0]) begin
        lb_we = 1'b1;
      end else begin
        out_data_d  = chan_max(lb_rdata, pair_max);
        out_valid_d = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q        <= '0;
      row_q        <= '0;
      hold_q       <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else if (clk_en) begin
      col_q        <= col_d;
      row_q        <= row_d;
      hold_q       <= hold_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  // NOTE: the line buffer is not reset; row 0 of every frame rewrites it before any read.
  always_ff @(posedge clk) begin
    if (lb_we) line_buf[lb_idx] <= pair_max;
  end

  assign output_data = out_data_q;
  assign out_valid   = out_valid_q;
  assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_max_pooling_layer.sv
// Bench for max_pooling_layer: three 2-channel, 8-bit instances (IN_SIZE 4, 5, 2) share
// the stimulus; a table of hand vectors plus random frames against a window-max model.
module tb_max_pooling_layer;

  localparam int DW = 16;

  typedef struct packed {
    int                   size;
    int                   nexp;
    logic [24:0][DW-1:0]  pix;
    logic [3:0][DW-1:0]   exp;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n, clk_en, iv;
  logic [DW-1:0] din;
  int            sel;
  logic [DW-1:0] od [3];
  logic          ov [3];
  logic          fd [3];

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] got_q[$];
  int            fd_pos[$];
  logic          en_last = 1'b0;

  vec_t tbl [4];

  always #5 clk = ~clk;

  max_pooling_layer #(.D_WIDTH(8), .CHANNELS(2), .IN_SIZE(4)) u_s4 (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .in_valid(iv && sel == 0),
    .input_data(din), .output_data(od[0]), .out_valid(ov[0]), .frame_done(fd[0]));
  max_pooling_layer #(.D_WIDTH(8), .CHANNELS(2), .IN_SIZE(5)) u_s5 (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .in_valid(iv && sel == 1),
    .input_data(din), .output_data(od[1]), .out_valid(ov[1]), .frame_done(fd[1]));
  max_pooling_layer #(.D_WIDTH(8), .CHANNELS(2), .IN_SIZE(2)) u_s2 (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .in_valid(iv && sel == 2),
    .input_data(din), .output_data(od[2]), .out_valid(ov[2]), .frame_done(fd[2]));

  // Collect results once per enabled edge so a held out_valid is not counted twice.
  always @(posedge clk) en_last <= clk_en;
  always @(negedge clk) begin
    if (rst_n && en_last) begin
      if (ov[sel]) got_q.push_back(od[sel]);
      if (fd[sel]) fd_pos.push_back(got_q.size());
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int size_sel(input int n);
    return (n == 4) ? 0 : (n == 5) ? 1 : 2;
  endfunction

  task automatic idle(input int k);
    repeat (k) begin
      @(negedge clk);
      iv = 1'b0;
      clk_en = 1'b1;
    end
  endtask

  task automatic start(input int n);
    idle(2);
    sel = size_sel(n);
    got_q.delete();
    fd_pos.delete();
  endtask

  task automatic send_pixels(input int n_pix, input logic [DW-1:0] pix[$],
                             input int gap, input bit rand_en);
    bit acc;
    int guard;
    for (int i = 0; i < n_pix; i++) begin
      acc = 1'b0;
      guard = 0;
      while (!acc) begin
        @(negedge clk);
        din = pix[i];
        iv = 1'b1;
        clk_en = rand_en ? ($urandom_range(0, 2) != 0) : 1'b1;
        acc = clk_en;
        guard++;
        if (guard > 1000) begin
          $display("FAIL stall: pixel %0d never accepted", i);
          $fatal(1);
        end
      end
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        iv = 1'b0;
        din = DW'($urandom);
        clk_en = rand_en ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
    end
  endtask

  // Reference: each output is the signed max of a full 2x2 window, per channel.
  task automatic model(input int n, input logic [DW-1:0] pix[$], input int base,
                       output logic [DW-1:0] res[$]);
    logic [DW-1:0]      w, p;
    logic signed [7:0]  v;
    int                 m;
    res.delete();
    for (int r = 0; r < n / 2; r++)
      for (int c = 0; c < n / 2; c++) begin
        w = '0;
        for (int ch = 0; ch < 2; ch++) begin
          m = -1000;
          for (int dr = 0; dr < 2; dr++)
            for (int dc = 0; dc < 2; dc++) begin
              p = pix[base + (2*r + dr)*n + 2*c + dc];
              v = p[ch*8 +: 8];
              if (int'(v) > m) m = int'(v);
            end
          w[ch*8 +: 8] = m[7:0];
        end
        res.push_back(w);
      end
  endtask

  task automatic verify(input string name, input logic [DW-1:0] exp[$], input int fpos[$]);
    idle(3);
    check($sformatf("%s count", name), got_q.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      if (i < got_q.size()) check($sformatf("%s out[%0d]", name, i), got_q[i], exp[i]);
    check($sformatf("%s frame_done count", name), fd_pos.size(), fpos.size());
    for (int i = 0; i < fpos.size(); i++)
      if (i < fd_pos.size()) check($sformatf("%s frame_done pos[%0d]", name, i), fd_pos[i], fpos[i]);
  endtask

  function automatic void table_frame(input int t, output logic [DW-1:0] q[$]);
    q.delete();
    for (int i = 0; i < tbl[t].size * tbl[t].size; i++) q.push_back(tbl[t].pix[i]);
  endfunction

  function automatic void table_exp(input int t, output logic [DW-1:0] q[$]);
    q.delete();
    for (int i = 0; i < tbl[t].nexp; i++) q.push_back(tbl[t].exp[i]);
  endfunction

  initial begin
    logic [DW-1:0] q[$], e[$], e2[$];
    int            fp[$];
    int            n, nf, gap;
    bit            ren;

    tbl[0] = '0;
    tbl[0].size = 4; tbl[0].nexp = 4;
    for (int i = 0; i < 16; i++) tbl[0].pix[i] = {8'(-(i + 1)), 8'(i + 1)};
    tbl[0].exp[0] = 16'hFF06; tbl[0].exp[1] = 16'hFD08;
    tbl[0].exp[2] = 16'hF70E; tbl[0].exp[3] = 16'hF510;
    tbl[1] = '0;
    tbl[1].size = 2; tbl[1].nexp = 1;
    tbl[1].pix[0] = 16'h8080; tbl[1].pix[1] = 16'h80FF;
    tbl[1].pix[2] = 16'h80FB; tbl[1].pix[3] = 16'h80FE;
    tbl[1].exp[0] = 16'h80FF;
    tbl[2] = '0;
    tbl[2].size = 2; tbl[2].nexp = 1;
    tbl[2].pix[0] = 16'hF903; tbl[2].pix[1] = 16'hFD09;
    tbl[2].pix[2] = 16'hF701; tbl[2].pix[3] = 16'hFC02;
    tbl[2].exp[0] = 16'hFD09;
    tbl[3] = '0;
    tbl[3].size = 5; tbl[3].nexp = 4;
    for (int i = 0; i < 25; i++) tbl[3].pix[i] = {8'h00, 8'(i + 1)};
    tbl[3].exp[0] = 16'h0007; tbl[3].exp[1] = 16'h0009;
    tbl[3].exp[2] = 16'h0011; tbl[3].exp[3] = 16'h0013;

    rst_n = 1'b0; clk_en = 1'b1; iv = 1'b0; din = '0; sel = 0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset out_valid[%0d]", k), ov[k], 1'b0);
      check($sformatf("reset output_data[%0d]", k), od[k], 16'h0000);
      check($sformatf("reset frame_done[%0d]", k), fd[k], 1'b0);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    check("idle out_valid", ov[0], 1'b0);

    for (int t = 0; t < 4; t++) begin
      start(tbl[t].size);
      table_frame(t, q);
      send_pixels(q.size(), q, 0, 1'b0);
      table_exp(t, e);
      fp = '{tbl[t].nexp};
      verify($sformatf("table%0d", t), e, fp);
    end

    start(4);
    table_frame(0, q);
    send_pixels(16, q, 3, 1'b1);
    table_exp(0, e);
    fp = '{4};
    verify("gaps+clk_en", e, fp);

    start(2);
    table_frame(2, q);
    send_pixels(4, q, 0, 1'b0);
    @(negedge clk);
    iv = 1'b0;
    clk_en = 1'b0;
    check("hold out_valid first", ov[2], 1'b1);
    repeat (3) begin
      @(posedge clk);
      #1;
      check("hold out_valid", ov[2], 1'b1);
      check("hold frame_done", fd[2], 1'b1);
      check("hold output_data", od[2], 16'hFD09);
    end
    @(negedge clk);
    clk_en = 1'b1;
    @(posedge clk);
    #1;
    check("release out_valid", ov[2], 1'b0);
    check("release frame_done", fd[2], 1'b0);
    table_exp(2, e);
    fp = '{1};
    verify("hold", e, fp);

    start(4);
    table_frame(0, q);
    send_pixels(6, q, 0, 1'b0);
    @(posedge clk);
    #1;
    check("pre-reset out_valid", ov[0], 1'b1);
    check("pre-reset output_data", od[0], 16'hFF06);
    rst_n = 1'b0;
    #1;
    check("async reset out_valid", ov[0], 1'b0);
    check("async reset output_data", od[0], 16'h0000);
    check("async reset frame_done", fd[0], 1'b0);
    @(negedge clk);
    iv = 1'b0;
    clk_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    start(4);
    send_pixels(16, q, 0, 1'b0);
    table_exp(0, e);
    fp = '{4};
    verify("after reset", e, fp);

    start(4);
    table_frame(0, q);
    for (int i = 0; i < 16; i++) q.push_back(DW'($urandom));
    send_pixels(32, q, 0, 1'b0);
    table_exp(0, e);
    model(4, q, 16, e2);
    e = {e, e2};
    fp = '{4, 8};
    verify("back-to-back", e, fp);

    for (int it = 0; it < 8; it++) begin
      case ($urandom_range(0, 2))
        0:       n = 4;
        1:       n = 5;
        default: n = 2;
      endcase
      nf  = $urandom_range(1, 2);
      gap = $urandom_range(0, 2);
      ren = 1'($urandom_range(0, 1));
      q.delete();
      for (int i = 0; i < nf * n * n; i++) q.push_back(DW'($urandom));
      e.delete();
      fp.delete();
      for (int f = 0; f < nf; f++) begin
        model(n, q, f * n * n, e2);
        e = {e, e2};
        fp.push_back((f + 1) * (n / 2) * (n / 2));
      end
      start(n);
      send_pixels(q.size(), q, gap, ren);
      verify($sformatf("random%0d n=%0d", it, n), e, fp);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
